// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register pending-write bitmap, in-flight write counter and shared-divider ownership.
// Optional macro SCB_WB_BYPASS_EN lets a same-cycle writeback release its register to the hazard check.
module issue_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_vld,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_wb,
  input  logic        dec_div,
  input  logic        wb_vld,
  input  logic [4:0]  wb_rd,
  input  logic        div_done,
  input  logic        flush,
  output logic        issue_rdy,
  output logic [31:0] busy_vec,
  output logic [2:0]  inflight,
  output logic        div_busy
);

  localparam int unsigned REG_N = 32;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } div_state_e;

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [REG_N-1:0] r_busy;
  logic [REG_N-1:0] w_busy_nxt;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] w_inflight_nxt;

  logic             w_wb_eff;
  logic [REG_N-1:0] w_wb_onehot;
  logic [REG_N-1:0] w_rd_onehot;
  logic [REG_N-1:0] w_busy_chk;
  logic             w_raw;
  logic             w_waw;
  logic             w_full;
  logic             w_div_blk;
  logic             w_fire;
  logic             w_set;

  // A writeback with nothing outstanding is spurious and has no effect.
  assign w_wb_eff    = wb_vld & (r_inflight != '0);
  assign w_wb_onehot = REG_N'(1) << wb_rd;
  assign w_rd_onehot = REG_N'(1) << dec_rd;

`ifdef SCB_WB_BYPASS_EN
  assign w_busy_chk = r_busy & ~({REG_N{w_wb_eff}} & w_wb_onehot);
`else
  assign w_busy_chk = r_busy;
`endif

  assign w_raw     = (dec_use_rs1 & w_busy_chk[dec_rs1]) | (dec_use_rs2 & w_busy_chk[dec_rs2]);
  assign w_waw     = dec_wb & w_busy_chk[dec_rd];
  assign w_full    = dec_wb & (r_inflight == CNT_W'(MAX_INFLIGHT));
  assign w_div_blk = dec_div & (r_state == S_BUSY);

  assign issue_rdy = ~flush & ~w_raw & ~w_waw & ~w_full & ~w_div_blk;
  assign w_fire    = dec_vld & issue_rdy;
  assign w_set     = w_fire & dec_wb & (dec_rd != 5'd0);

  // Pending-write bitmap: issue set wins over same-index writeback clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wb_eff) w_busy_nxt = w_busy_nxt & ~w_wb_onehot;
      if (w_set)    w_busy_nxt = w_busy_nxt | w_rd_onehot;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Outstanding writes, including rd=0 writers that never mark the bitmap.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (flush) begin
      w_inflight_nxt = '0;
    end else begin
      case ({w_fire & dec_wb, w_wb_eff})
        2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
        2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1);
        default: w_inflight_nxt = r_inflight;
      endcase
    end
  end

  // Divider ownership next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fire & dec_div) w_state_nxt = S_BUSY;
      S_BUSY:  if (div_done)         w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= '0;
      r_inflight <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  assign busy_vec = r_busy;
  assign inflight = r_inflight;
  assign div_busy = (r_state == S_BUSY);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: reference model pushes expected next state per cycle, popped after the edge.
module tb_issue_scoreboard;

  localparam int unsigned MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        dec_vld;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic [4:0]  dec_rd;
  logic        dec_wb;
  logic        dec_div;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic        div_done;
  logic        flush;
  logic        issue_rdy;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic        div_busy;

  issue_scoreboard #(.MAX_INFLIGHT(MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_vld     (dec_vld),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_use_rs1 (dec_use_rs1),
    .dec_use_rs2 (dec_use_rs2),
    .dec_rd      (dec_rd),
    .dec_wb      (dec_wb),
    .dec_div     (dec_div),
    .wb_vld      (wb_vld),
    .wb_rd       (wb_rd),
    .div_done    (div_done),
    .flush       (flush),
    .issue_rdy   (issue_rdy),
    .busy_vec    (busy_vec),
    .inflight    (inflight),
    .div_busy    (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] busy;
    logic [2:0]  inf;
    logic        div;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_busy;
  int unsigned m_inf;
  logic        m_div;
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; dec_vld = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_rd = 5'd0; dec_wb = 1'b0;
    dec_div = 1'b0; wb_vld = 1'b0; wb_rd = 5'd0; div_done = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wb, input logic div);
    idle_inputs();
    dec_vld = 1'b1; dec_rd = rd; dec_wb = wb; dec_div = div;
  endtask

  // One clock: check issue_rdy against the model, queue expected state, compare after the edge.
  task automatic step();
    exp_t        e;
    logic [31:0] chk;
    logic        wb_eff;
    logic        rdy;
    logic        fire;
    #1;
    wb_eff = wb_vld && (m_inf != 0);
    chk    = m_busy;
`ifdef SCB_WB_BYPASS_EN
    if (wb_eff) chk[wb_rd] = 1'b0;
`endif
    rdy = !flush
        && !((dec_use_rs1 && chk[dec_rs1]) || (dec_use_rs2 && chk[dec_rs2]))
        && !(dec_wb && chk[dec_rd])
        && !(dec_wb && (m_inf == MAX))
        && !(dec_div && m_div);
    check_eq("issue_rdy", 32'(issue_rdy), 32'(rdy));
    fire = dec_vld && rdy;
    if (!rst_n || flush) begin
      m_busy = '0; m_inf = 0; m_div = 1'b0;
    end else begin
      if (wb_eff) begin
        m_busy[wb_rd] = 1'b0;
        m_inf = m_inf - 1;
      end
      if (fire && dec_wb) begin
        if (dec_rd != 5'd0) m_busy[dec_rd] = 1'b1;
        m_inf = m_inf + 1;
      end
      if (!m_div && fire && dec_div) m_div = 1'b1;
      else if (m_div && div_done)    m_div = 1'b0;
    end
    e.busy = m_busy; e.inf = 3'(m_inf); e.div = m_div;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("busy_vec", busy_vec, e.busy);
    check_eq("inflight", 32'(inflight), 32'(e.inf));
    check_eq("div_busy", 32'(div_busy), 32'(e.div));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_busy = '0; m_inf = 0; m_div = 1'b0;
    step();
    check_eq("rst_busy", busy_vec, 32'd0);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_div_busy", 32'(div_busy), 32'd0);

    // RAW stall on rd=5 then release by writeback
    issue(5'd5, 1'b1, 1'b0); step();
    check_eq("raw_busy5", busy_vec, 32'h0000_0020);
    idle_inputs(); dec_vld = 1'b1; dec_use_rs1 = 1'b1; dec_rs1 = 5'd5;
    #1 check_eq("raw_stall", 32'(issue_rdy), 32'd0);
    step();
    wb_vld = 1'b1; wb_rd = 5'd5; step();
    wb_vld = 1'b0; step();
    check_eq("raw_done_busy", busy_vec, 32'd0);
    check_eq("raw_done_inflight", 32'(inflight), 32'd0);

    // Fill to MAX_INFLIGHT, fifth stalls until a writeback
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 1'b1, 1'b0); step();
    end
    check_eq("full_inflight4", 32'(inflight), 32'd4);
    issue(5'd6, 1'b1, 1'b0);
    #1 check_eq("full_stall", 32'(issue_rdy), 32'd0);
    step();
    wb_vld = 1'b1; wb_rd = 5'd1; step();
    wb_vld = 1'b0;
    #1 check_eq("full_release", 32'(issue_rdy), 32'd1);
    step();
    check_eq("full_inflight_after", 32'(inflight), 32'd4);
    check_eq("full_busy_after", busy_vec, 32'h0000_005C);

    // Flush with pending writes and divider owned
    idle_inputs(); flush = 1'b1; step();
    issue(5'd4, 1'b1, 1'b0); step();
    issue(5'd5, 1'b1, 1'b0); step();
    issue(5'd6, 1'b1, 1'b0); step();
    issue(5'd7, 1'b1, 1'b1); step();
    check_eq("fl_pre_busy", busy_vec, 32'h0000_00F0);
    check_eq("fl_pre_inflight", 32'(inflight), 32'd4);
    check_eq("fl_pre_div", 32'(div_busy), 32'd1);
    issue(5'd8, 1'b1, 1'b0); flush = 1'b1; wb_vld = 1'b1; wb_rd = 5'd4; div_done = 1'b1;
    #1 check_eq("fl_rdy", 32'(issue_rdy), 32'd0);
    step();
    check_eq("fl_busy", busy_vec, 32'd0);
    check_eq("fl_inflight", 32'(inflight), 32'd0);
    check_eq("fl_div", 32'(div_busy), 32'd0);

    // Divider ownership handoff
    issue(5'd0, 1'b0, 1'b1); step();
    check_eq("div_owned", 32'(div_busy), 32'd1);
    issue(5'd0, 1'b0, 1'b1);
    #1 check_eq("div_stall", 32'(issue_rdy), 32'd0);
    step();
    div_done = 1'b1; step();
    div_done = 1'b0;
    #1 check_eq("div_freed", 32'(div_busy), 32'd0);
    check_eq("div_second_rdy", 32'(issue_rdy), 32'd1);
    step();
    check_eq("div_second_owned", 32'(div_busy), 32'd1);
    idle_inputs(); div_done = 1'b1; step();
    idle_inputs(); div_done = 1'b1; step();
    check_eq("div_done_idle", 32'(div_busy), 32'd0);

    // Same-cycle issue and writeback to rd=7
    issue(5'd3, 1'b1, 1'b0); step();
    issue(5'd7, 1'b1, 1'b0); wb_vld = 1'b1; wb_rd = 5'd7;
    #1 check_eq("same_rdy", 32'(issue_rdy), 32'd1);
    step();
    check_eq("same_busy7", 32'(busy_vec[7]), 32'd1);
    check_eq("same_inflight", 32'(inflight), 32'd1);

    // rd=0 writer and spurious writeback
    idle_inputs(); flush = 1'b1; step();
    issue(5'd0, 1'b1, 1'b0); step();
    check_eq("rd0_busy", busy_vec, 32'd0);
    check_eq("rd0_inflight", 32'(inflight), 32'd1);
    idle_inputs(); wb_vld = 1'b1; step();
    idle_inputs(); wb_vld = 1'b1; wb_rd = 5'd5; step();
    check_eq("wb_empty_inflight", 32'(inflight), 32'd0);
    check_eq("wb_empty_busy", busy_vec, 32'd0);

    // Reset mid-operation beats flush and issue
    issue(5'd9, 1'b1, 1'b1); step();
    issue(5'd10, 1'b1, 1'b0); rst_n = 1'b0; flush = 1'b1; step();
    check_eq("mid_rst_busy", busy_vec, 32'd0);
    check_eq("mid_rst_inflight", 32'(inflight), 32'd0);
    check_eq("mid_rst_div", 32'(div_busy), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      dec_vld     = 1'($urandom_range(0, 1));
      dec_rs1     = 5'($urandom_range(0, 7));
      dec_rs2     = 5'($urandom_range(0, 7));
      dec_use_rs1 = 1'($urandom_range(0, 1));
      dec_use_rs2 = 1'($urandom_range(0, 1));
      dec_rd      = 5'($urandom_range(0, 7));
      dec_wb      = 1'($urandom_range(0, 1));
      dec_div     = ($urandom_range(0, 3) == 0);
      wb_vld      = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      div_done    = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 31) == 0);
      rst_n       = ($urandom_range(0, 63) != 0);
      step();
    end

    idle_inputs(); step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
